// File: rtl/rv32_divider_pkg.sv
// Shared encodings for the RV32M divider: funct3[1:0] op codes and FSM states.
// The op encodings match the decoder's M-extension funct3 decode.
package rv32_divider_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // funct3[0] clear means a signed operation, funct3[1] set selects the remainder.
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_rem_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/rv32_divider_if.sv
// Request/response bundle between the execute stage and the divider.
// The master issues operations and the slave (the divider) returns results.
interface rv32_divider_if #(parameter int n = 32);

  logic         start;
  logic [1:0]   op;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic         busy;
  logic         done;
  logic [n-1:0] result;

  modport master (
    output start, op, A, B,
    input  busy, done, result
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, result
  );

endinterface

// File: rtl/rv32_divider_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit and
// conditionally subtract the divisor using a ripple chain of adder cells.
module div_step #(
  parameter int n = 32
) (
  input  logic [n-1:0] rem_i,
  input  logic [n-1:0] divisor_i,
  input  logic         dvd_bit_i,
  output logic [n-1:0] rem_o,
  output logic         q_bit_o
);

  logic [n:0]   shifted;
  logic [n:0]   sub_b;
  logic [n-1:0] diff;
  logic [n+1:0] carry;

  assign shifted  = {rem_i, dvd_bit_i};
  assign sub_b    = ~{1'b0, divisor_i};
  assign carry[0] = 1'b1;

  // Subtraction as shifted + ~divisor + 1; a carry out of the top cell means no borrow.
  for (genvar i = 0; i < n; i++) begin : g_cell
    assign diff[i]      = shifted[i] ^ sub_b[i] ^ carry[i];
    assign carry[i+1]   = (shifted[i] & sub_b[i]) | (carry[i] & (shifted[i] ^ sub_b[i]));
  end

  // The top cell's sum is always zero after a successful subtract, so only its carry is kept.
  assign carry[n+1] = (shifted[n] & sub_b[n]) | (carry[n] & (shifted[n] ^ sub_b[n]));

  assign q_bit_o = carry[n+1];
  assign rem_o   = q_bit_o ? diff : shifted[n-1:0];

endmodule

// File: rtl/rv32_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU: one iteration per clock,
// with a single-cycle fast path for divide-by-zero and signed overflow.
module rv32_divider
  import rv32_divider_pkg::*;
#(
  parameter int n = 32
) (
  input logic          clk,
  input logic          rst,
  rv32_divider_if.slave bus
);

  localparam int CW = $clog2(n + 1);
  localparam logic [n-1:0] MIN_NEG = {1'b1, {(n-1){1'b0}}};

  state_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]   op_q, op_d;
  logic [n-1:0] dvd_q, dvd_d;
  logic [n-1:0] dvs_q, dvs_d;
  logic [n-1:0] rem_q, rem_d;
  logic         neg_q_q, neg_q_d;
  logic         neg_r_q, neg_r_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [n-1:0] result_q, result_d;

  logic [n-1:0] step_rem;
  logic         step_q;
  logic [n-1:0] quot_next;
  logic         in_signed;
  logic         in_rem;

  div_step #(.n(n)) u_step (
    .rem_i     (rem_q),
    .divisor_i (dvs_q),
    .dvd_bit_i (dvd_q[n-1]),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  // The dividend register doubles as the quotient: quotient bits enter at the bottom.
  assign quot_next = {dvd_q[n-2:0], step_q};
  assign in_signed = is_signed_op(bus.op);
  assign in_rem    = is_rem_op(bus.op);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          op_d = bus.op;
          if (bus.B == '0) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = in_rem ? bus.A : '1;
          end else if (in_signed && bus.A == MIN_NEG && bus.B == '1) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = in_rem ? '0 : bus.A;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            cnt_d   = CW'(n);
            rem_d   = '0;
            dvd_d   = (in_signed && bus.A[n-1]) ? -bus.A : bus.A;
            dvs_d   = (in_signed && bus.B[n-1]) ? -bus.B : bus.B;
            neg_q_d = in_signed & (bus.A[n-1] ^ bus.B[n-1]);
            neg_r_d = in_signed & bus.A[n-1];
          end
        end
      end

      S_RUN: begin
        dvd_d = quot_next;
        rem_d = step_rem;
        cnt_d = cnt_q - CW'(1);
        // This cycle performs the final iteration, so the result is formed from the step outputs.
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (is_rem_op(op_q)) begin
            result_d = neg_r_q ? -step_rem : step_rem;
          end else begin
            result_d = neg_q_q ? -quot_next : quot_next;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_rv32_divider.sv
// Directed bench for rv32_divider: latency, busy window, fast paths, ignored
// starts, mid-operation reset and back-to-back issue with hand-computed results.
module tb_rv32_divider;

  logic clk;
  logic rst;
  int   nChecks = 0;
  int   nFails  = 0;

  rv32_divider_if #(.n(32)) bus ();

  rv32_divider #(.n(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Present a request at a negedge; returns at the negedge after the sampling edge (cycle 1).
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = 32'h0BAD_F00D;
    bus.B     = 32'h0000_0003;
  endtask

  // Wait for done counting cycles from startCycle; busy must be high on every cycle before done.
  task automatic waitDone(input string tag, input int startCycle, input int expLat, input logic [31:0] expRes);
    int c;
    int busyBad;
    c       = startCycle;
    busyBad = 0;
    while (bus.done !== 1'b1 && c < 40) begin
      if (bus.busy !== 1'b1) busyBad++;
      @(negedge clk);
      c++;
    end
    checkOutput({tag, " latency"}, c, expLat);
    checkOutput({tag, " result"}, bus.result, expRes);
    checkOutput({tag, " busy at done"}, {31'b0, bus.busy}, 32'd0);
    checkOutput({tag, " busy window"}, busyBad, 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int expLat, input logic [31:0] expRes);
    applyStimulus(op, a, b);
    waitDone(tag, 1, expLat, expRes);
  endtask

  task automatic checkPulseEnd(input string tag, input logic [31:0] expRes);
    @(negedge clk);
    checkOutput({tag, " done pulse"}, {31'b0, bus.done}, 32'd0);
    checkOutput({tag, " result held"}, bus.result, expRes);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("reset done", {31'b0, bus.done}, 32'd0);
    checkOutput("reset result", bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    runOp("divu 100/7", 2'b01, 32'd100, 32'd7, 33, 32'd14);
    checkPulseEnd("divu 100/7", 32'd14);
    runOp("remu 100/7", 2'b11, 32'd100, 32'd7, 33, 32'd2);
    checkPulseEnd("remu 100/7", 32'd2);

    runOp("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
    runOp("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
    runOp("div 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
    runOp("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 33, 32'd1);
    runOp("divu big/2", 2'b01, 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC);
    runOp("div min/2", 2'b00, 32'h8000_0000, 32'd2, 33, 32'hC000_0000);
    checkPulseEnd("div min/2", 32'hC000_0000);

    runOp("divu 5/0", 2'b01, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    checkPulseEnd("divu 5/0", 32'hFFFF_FFFF);
    runOp("rem 5/0", 2'b10, 32'd5, 32'd0, 1, 32'd5);
    runOp("div 5/0", 2'b00, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    runOp("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    runOp("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
    checkPulseEnd("rem ovf", 32'd0);
    runOp("divu min/-1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0);
    runOp("remu min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000);
    checkPulseEnd("remu min/-1", 32'h8000_0000);

    // A second start during cycle 5 must not disturb the operation in flight.
    applyStimulus(2'b01, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.A     = 32'd50;
    bus.B     = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone("ignored start", 6, 33, 32'd14);
    checkPulseEnd("ignored start", 32'd14);

    // Reset at cycle 10 of a new operation, with a start in the same cycle that must be dropped.
    applyStimulus(2'b01, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.A     = 32'd9;
    bus.B     = 32'd0;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    checkOutput("mid-run reset busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("mid-run reset done", {31'b0, bus.done}, 32'd0);
    checkOutput("mid-run reset result", bus.result, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("dropped start busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("dropped start done", {31'b0, bus.done}, 32'd0);
    runOp("divu 9/3", 2'b01, 32'd9, 32'd3, 33, 32'd3);
    checkPulseEnd("divu 9/3", 32'd3);

    // Back-to-back: the REMU is issued in the DONE cycle of the DIVU.
    runOp("b2b divu", 2'b01, 32'd100, 32'd7, 33, 32'd14);
    applyStimulus(2'b11, 32'd17, 32'd5);
    checkOutput("b2b first held", bus.result, 32'd14);
    checkOutput("b2b done dropped", {31'b0, bus.done}, 32'd0);
    waitDone("b2b remu", 1, 33, 32'd2);
    checkPulseEnd("b2b remu", 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
